// File: rtl/par_ser_sched_pkg.sv
// Shared definitions for the parallel-to-serial scheduler: default comma word
// and FSM state encoding.
package par_ser_sched_pkg;
  localparam logic [7:0] IDLE_WORD_DEF = 8'hBC;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    DATA = 2'd2
  } state_e;
endpackage

// File: rtl/par_ser_sched_if.sv
// Word-source handshake plus serial-lane outputs of the scheduler.
interface par_ser_sched_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] DATA_IN;
  logic             VALID_IN;
  logic             READY_OUT;
  logic             DATA_OUT;
  logic             ACTIVE;
  logic             BIT_TICK;

  modport master (output DATA_IN, VALID_IN,
                  input  READY_OUT, DATA_OUT, ACTIVE, BIT_TICK);
  modport slave  (input  DATA_IN, VALID_IN,
                  output READY_OUT, DATA_OUT, ACTIVE, BIT_TICK);
endinterface

// File: rtl/par_ser_sched_bit_tick_gen.sv
// Bit-rate divider: free-running 0..DIV-1 counter, tick on the last count.
module bit_tick_gen #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bit_tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_div_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_div_cnt <= '0;
    else if (r_div_cnt == LAST) r_div_cnt <= '0;
    else                        r_div_cnt <= r_div_cnt + 1'b1;
  end

  // With DIV=1 the counter is pinned at 0, so the tick is permanently high.
  assign o_bit_tick = (r_div_cnt == LAST);
endmodule

// File: rtl/par_ser_sched.sv
// Serializes buffered words MSB-first at one bit per DIV clocks, filling gaps
// with IDLE_WORD and leading with NSYNC sync words after reset. WIDTH >= 2.
module par_ser_sched
  import par_ser_sched_pkg::*;
#(
  parameter int             WIDTH     = 8,
  parameter int             DIV       = 4,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(IDLE_WORD_DEF),
  parameter int             NSYNC     = 2
) (
  input logic CLK,
  input logic RESET,
  par_ser_sched_if.slave bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (NSYNC > 1) ? $clog2(NSYNC) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  state_e           r_state;
  logic [SW-1:0]    r_sync_cnt;
  logic [IW-1:0]    r_bit_idx;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_full;
  logic             w_tick;
  logic             w_accept;

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .o_bit_tick (w_tick)
  );

  assign bus.READY_OUT = !r_buf_full && (r_state != SYNC);
  assign bus.DATA_OUT  = r_sreg[WIDTH-1];
  assign bus.ACTIVE    = (r_state == DATA);
  assign bus.BIT_TICK  = w_tick;
  assign w_accept      = bus.VALID_IN && bus.READY_OUT;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= SYNC;
      r_sync_cnt <= SW'(NSYNC - 1);
      r_bit_idx  <= '0;
      r_sreg     <= IDLE_WORD;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      // Accept and drain never coincide: READY_OUT is low while the buffer is full.
      if (w_accept) begin
        r_buf      <= bus.DATA_IN;
        r_buf_full <= 1'b1;
      end
      if (w_tick) begin
        if (r_bit_idx != LAST_BIT) begin
          r_sreg    <= {r_sreg[WIDTH-2:0], 1'b0};
          r_bit_idx <= r_bit_idx + 1'b1;
        end else begin
          r_bit_idx <= '0;
          if (r_state == SYNC) begin
            // sync_cnt == 0 means the word just finished was the last sync word.
            r_sreg <= IDLE_WORD;
            if (r_sync_cnt == '0) r_state    <= IDLE;
            else                  r_sync_cnt <= r_sync_cnt - 1'b1;
          end else if (r_buf_full) begin
            r_sreg     <= r_buf;
            r_buf_full <= 1'b0;
            r_state    <= DATA;
          end else begin
            r_sreg  <= IDLE_WORD;
            r_state <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_par_ser_sched.sv
// Directed bench: sync sequence, single/back-to-back words, handshake hold,
// mid-word reset on a DIV=4 instance, and a DIV=1 instance.
module tb_par_ser_sched;
  logic CLK = 1'b0;
  logic RESET;
  logic RESET1;
  int   npass = 0;
  int   ntot  = 0;

  par_ser_sched_if #(.WIDTH(8)) b0 ();
  par_ser_sched_if #(.WIDTH(8)) b1 ();

  par_ser_sched #(.WIDTH(8), .DIV(4), .IDLE_WORD(8'hBC), .NSYNC(2)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(b0));
  par_ser_sched #(.WIDTH(8), .DIV(1), .IDLE_WORD(8'hBC), .NSYNC(1)) dut1 (
    .CLK(CLK), .RESET(RESET1), .bus(b1));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Checks offsets o0..o1-1 of a DIV=4 word on dut0, stepping after each.
  task automatic chk_stream(input string tag, input logic [7:0] w, input logic act,
                            input int o0, input int o1);
    for (int o = o0; o < o1; o++) begin
      chk({tag, "_bit"}, b0.DATA_OUT, w[7 - o/4]);
      chk({tag, "_act"}, b0.ACTIVE, act);
      step();
    end
  endtask

  task automatic chk_sync(input string tag);
    logic [7:0] bc;
    bc = 8'hBC;
    for (int k = 0; k < 64; k++) begin
      chk({tag, "_bit"},   b0.DATA_OUT, bc[7 - (k/4) % 8]);
      chk({tag, "_ready"}, b0.READY_OUT, 1'b0);
      chk({tag, "_act"},   b0.ACTIVE, 1'b0);
      chk({tag, "_tick"},  b0.BIT_TICK, (k % 4) == 3);
      step();
    end
    chk({tag, "_ready_rise"}, b0.READY_OUT, 1'b1);
  endtask

  initial begin
    logic [7:0] bc;
    logic [7:0] w3c;
    bc  = 8'hBC;
    w3c = 8'h3C;
    RESET  = 1'b1;
    RESET1 = 1'b1;
    b0.DATA_IN = 8'h00; b0.VALID_IN = 1'b0;
    b1.DATA_IN = 8'h00; b1.VALID_IN = 1'b0;
    repeat (3) step();

    chk("rst_dout",  b0.DATA_OUT, 1'b1);
    chk("rst_ready", b0.READY_OUT, 1'b0);
    chk("rst_act",   b0.ACTIVE, 1'b0);
    chk("rst_tick",  b0.BIT_TICK, 1'b0);
    RESET = 1'b0;

    chk_sync("sync");                               // k = 64

    // Single word 0xA5
    b0.DATA_IN = 8'hA5; b0.VALID_IN = 1'b1;
    step();                                         // k = 65
    b0.VALID_IN = 1'b0;
    chk("single_full", b0.READY_OUT, 1'b0);
    repeat (31) step();                             // k = 96
    chk("single_drain_ready", b0.READY_OUT, 1'b1);
    chk_stream("single", 8'hA5, 1'b1, 0, 32);       // k = 128
    chk("single_after_act", b0.ACTIVE, 1'b0);
    chk("single_after_dout", b0.DATA_OUT, 1'b1);

    // Back-to-back 0x01 then 0xFE; 0xFE presented while buffer full must not overwrite
    b0.DATA_IN = 8'h01; b0.VALID_IN = 1'b1;
    step();                                         // k = 129
    b0.DATA_IN = 8'hFE;
    for (int k = 129; k < 160; k++) begin
      chk("hold_ready", b0.READY_OUT, 1'b0);
      chk("hold_idle_act", b0.ACTIVE, 1'b0);
      step();
    end
    chk("b2b_ready", b0.READY_OUT, 1'b1);
    chk_stream("b2b_01", 8'h01, 1'b1, 0, 1);        // k = 161
    b0.VALID_IN = 1'b0;
    chk_stream("b2b_01", 8'h01, 1'b1, 1, 32);       // k = 192
    chk_stream("b2b_fe", 8'hFE, 1'b1, 0, 32);       // k = 224
    chk("b2b_after_act", b0.ACTIVE, 1'b0);
    chk("b2b_after_dout", b0.DATA_OUT, 1'b1);

    // Mid-word reset with a second word waiting in the buffer
    b0.DATA_IN = 8'hA5; b0.VALID_IN = 1'b1;
    step();                                         // k = 225
    b0.VALID_IN = 1'b0;
    repeat (31) step();                             // k = 256
    chk("mid_ready", b0.READY_OUT, 1'b1);
    b0.DATA_IN = 8'h55; b0.VALID_IN = 1'b1;
    chk_stream("mid_a5", 8'hA5, 1'b1, 0, 1);        // k = 257
    b0.VALID_IN = 1'b0;
    chk("mid_buf_full", b0.READY_OUT, 1'b0);
    chk_stream("mid_a5", 8'hA5, 1'b1, 1, 12);       // k = 268, bit 3
    chk("mid_bit3", b0.DATA_OUT, 1'b0);
    RESET = 1'b1;
    step();
    chk("mid_rst_dout",  b0.DATA_OUT, 1'b1);
    chk("mid_rst_act",   b0.ACTIVE, 1'b0);
    chk("mid_rst_ready", b0.READY_OUT, 1'b0);
    RESET = 1'b0;
    chk_sync("resync");
    chk_stream("discard", bc, 1'b0, 0, 32);

    // DIV=1 instance
    chk("d1_rst_tick", b1.BIT_TICK, 1'b1);
    chk("d1_rst_dout", b1.DATA_OUT, 1'b1);
    chk("d1_rst_ready", b1.READY_OUT, 1'b0);
    RESET1 = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("d1_sync_tick", b1.BIT_TICK, 1'b1);
      chk("d1_sync_bit", b1.DATA_OUT, bc[7 - j]);
      chk("d1_sync_ready", b1.READY_OUT, 1'b0);
      step();
    end
    chk("d1_ready", b1.READY_OUT, 1'b1);
    b1.DATA_IN = 8'h3C; b1.VALID_IN = 1'b1;
    step();
    b1.VALID_IN = 1'b0;
    for (int j = 9; j < 16; j++) begin
      chk("d1_idle_act", b1.ACTIVE, 1'b0);
      chk("d1_idle_bit", b1.DATA_OUT, bc[7 - (j - 8)]);
      step();
    end
    for (int j = 16; j < 24; j++) begin
      chk("d1_data_tick", b1.BIT_TICK, 1'b1);
      chk("d1_data_bit", b1.DATA_OUT, w3c[7 - (j - 16)]);
      chk("d1_data_act", b1.ACTIVE, 1'b1);
      step();
    end
    chk("d1_after_act", b1.ACTIVE, 1'b0);
    chk("d1_after_dout", b1.DATA_OUT, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/par_ser_sched.md
# par_ser_sched

Single-clock scheduler that sequences the parallel-to-serial datapath at a programmable bit rate derived from `CLK`, replacing the separate divided clock with an enable tick. It accepts parallel words through a one-deep valid/ready buffer and emits them MSB-first on a serial line. When no data is pending it fills the line with an idle/comma word, so the link never stalls. After reset it sends a fixed number of sync words before accepting any data. It sits between the word source and the serial lane, in the same `CLK` domain as the existing 1 MHz divider.

## Interface
- `WIDTH`, 8: bits per word.
- `DIV`, 4: `CLK` cycles per serial bit. Must be at least 1.
- `IDLE_WORD`, 8'hBC: word sent when no data is pending; also used as the sync word.
- `NSYNC`, 2: number of idle words forced after reset before data is accepted. Must be at least 1.

Ports:
- `CLK` in 1: system clock. Everything is rising-edge.
- `RESET` in 1: synchronous, active-high reset.
- `DATA_IN` in WIDTH: parallel word. Sampled when `VALID_IN && READY_OUT`.
- `VALID_IN` in 1: source has a word.
- `READY_OUT` out 1: holding buffer is empty and the state is not SYNC.
- `DATA_OUT` out 1: serial bit, equal to `sreg[WIDTH-1]`.
- `ACTIVE` out 1: high while the word being shifted is real data, not idle.
- `BIT_TICK` out 1: one-cycle pulse at each bit boundary.

## Operation
- **Divider**
  - `div_cnt` counts 0..DIV-1 and wraps.
  - `BIT_TICK` = (`div_cnt == DIV-1`).
  - With DIV=1, `BIT_TICK` is constantly high.
- **On each tick**
  - If `bit_idx` < WIDTH-1: `sreg` shifts left by one (LSB filled with 0) and `bit_idx` increments.
  - If `bit_idx == WIDTH-1`, this is a word boundary:
    - `bit_idx` returns to 0.
    - `sreg` reloads with the next word, chosen as below.
- **Next-word selection at a word boundary**
  - SYNC state: load `IDLE_WORD`, decrement `sync_cnt`. When `sync_cnt` reaches 0 after this load, go to IDLE.
  - IDLE or DATA state, buffer full: load the buffer contents, clear `buf_full`, set state DATA.
  - IDLE or DATA state, buffer empty: load `IDLE_WORD`, set state IDLE.
- **Buffer**
  - Accept when `VALID_IN && READY_OUT`: `buf` <= `DATA_IN`, `buf_full` <= 1.
  - `READY_OUT` = `!buf_full && state != SYNC`. It is combinational from registers, not from `VALID_IN`.
  - Simultaneous accept and boundary drain: not possible in the same cycle, because `READY_OUT` is 0 while the buffer is full. The buffer refills starting the cycle after the drain.
- **`ACTIVE`** = (state == DATA). It changes only at word boundaries.
- **Reset** (synchronous, overrides any word in progress):
  - `div_cnt`=0, `bit_idx`=0, `sreg`=`IDLE_WORD`, `buf_full`=0.
  - `sync_cnt`=NSYNC-1; state=SYNC.
  - The reset load itself counts as the first sync word.
- **Reset output values:** `DATA_OUT`=`IDLE_WORD[WIDTH-1]` (1 for 0xBC), `READY_OUT`=0, `ACTIVE`=0, `BIT_TICK`=(DIV==1).

## Timing
- Each bit is held on `DATA_OUT` for exactly DIV cycles.
- Each word lasts WIDTH*DIV cycles.
- The first tick occurs DIV cycles after the cycle in which `RESET` is sampled low.
- `READY_OUT` rises at the cycle following the boundary that ends sync word NSYNC, i.e. NSYNC*WIDTH*DIV cycles after reset release.
- Latency: a word accepted at cycle t first appears on `DATA_OUT` the cycle after the next word-boundary tick at or after t+1. The maximum wait is WIDTH*DIV cycles.
- Back-to-back throughput:
  - If the source presents the next word within WIDTH*DIV-1 cycles of the previous drain, no idle word is inserted.
  - One word per WIDTH*DIV cycles is sustained.

## Structure
- **Shared package:** `IDLE_WORD` default (K28.5-style 8'hBC) and the state encoding `SYNC`=2'd0, `IDLE`=2'd1, `DATA`=2'd2.
- **Sub-module:** `bit_tick_gen` (the divider counter, `DIV` parameter, outputs `BIT_TICK`).
- **Top level holds:** FSM, buffer and shift register.

## Test plan
- **Reset and sync:** RESET high for 3 cycles, then low, with DIV=4, NSYNC=2 -> `DATA_OUT` streams 10111100 twice, `READY_OUT`=0 and `ACTIVE`=0 for the first 64 cycles, `READY_OUT`=1 at cycle 64.
- **Single word:** `DATA_IN`=8'hA5 with a `VALID_IN` pulse after sync -> at the next boundary `DATA_OUT`=10100101, each bit held 4 cycles; `ACTIVE` high for exactly 32 cycles; then 0xBC resumes.
- **Back-to-back:** `VALID_IN` held with 8'h01 then 8'hFE -> 00000001 followed immediately by 11111110, no idle gap, `ACTIVE` continuously high for 64 cycles.
- **Handshake hold:** `VALID_IN` high while `READY_OUT`=0 -> `DATA_IN` is not captured; buffer value unchanged until the drain.
- **Reset mid-word:** assert RESET at bit 3 of 8'hA5 -> the next cycle shows `DATA_OUT`=1, `ACTIVE`=0, state SYNC, the buffered word discarded, and the sync sequence restarts.
- **DIV=1:** `BIT_TICK` constantly 1; an 8'h3C word occupies exactly 8 cycles.
